fetch_aligner: RTL and testbench

Sits between the instruction-fetch port and the ID stage and produces the `IF_ID_t` stream consumed by decode. Takes 4-byte-aligned 32-bit fetch words and re-packs them into one instruction per transfer. This covers 32-bit instructions that straddle two fetch words. With RVC enabled, it also expands 16-bit compressed instructions into their 32-bit equivalents and emits them at halfword-granular PCs. It also absorbs pipeline redirects, including redirects to halfword-aligned targets.

---
 rtl/fetch_aligner.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_fetch_aligner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_aligner.sv
// fetch_aligner: repacks 4-byte-aligned fetch words into one instruction per
// transfer for the ID stage. Handles 32-bit instructions split across words
// and absorbs redirects.
// Build option WIV_RVC_EN: compiles in the RV64C expander, which allows
// halfword-granular PCs. Without it, the buffer holds whole words only, and
// any non-32-bit encoding is flagged illegal.

package WivDefines;
  typedef struct packed {
    logic        valid;
    logic [63:0] PC;
    logic [31:0] instruction;
  } IF_ID_t;
endpackage

module fetch_aligner #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [63:0]        fetch_pc_i,
  input  logic [31:0]        fetch_data_i,
  output WivDefines::IF_ID_t if_id_o,
  input  logic               id_ready_i,
  output logic               compressed_o,
  output logic               illegal_o,
  input  logic               flush_i,
  input  logic [63:0]        redirect_pc_i
);

  // Halfword buffer; hw[0] is the oldest halfword and sits at base_pc.
  logic [15:0] hw [3];
  logic [15:0] hw_nxt [3];
  logic [1:0]  count, count_nxt;
  logic [63:0] base_pc, base_pc_nxt;
  logic        skip_lo, skip_lo_nxt;

  logic        is32;
  logic [1:0]  need;
  logic        out_valid;
  logic        xfer;
  logic [1:0]  consume;
  logic [1:0]  remain;
  logic        accept;
  logic [31:0] out_instr;
  logic        out_comp;
  logic        out_ill;
  logic [63:0] redirect_eff;

`ifdef WIV_RVC_EN
  typedef struct packed {
    logic        illegal;
    logic [31:0] instr;
  } expand_t;

  // RV64C integer subset -> 32-bit equivalent; FP and reserved forms are illegal.
  function automatic expand_t expand(input logic [15:0] c);
    expand_t     r;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm, imm6;
    logic [11:0] j_off;
    logic [12:0] b_off;
    r.illegal = 1'b0;
    r.instr   = 32'h0;
    rd    = c[11:7];
    rs2   = c[6:2];
    rdp   = {2'b01, c[4:2]};
    rs1p  = {2'b01, c[9:7]};
    imm   = 12'h0;
    imm6  = {{6{c[12]}}, c[12], c[6:2]};
    j_off = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    b_off = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin  // C.ADDI4SPN
            imm       = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
            r.instr   = {imm, 5'd2, 3'b000, rdp, 7'b0010011};
            r.illegal = (c[12:5] == 8'h0);
          end
          3'b010: begin  // C.LW
            imm     = {5'b0, c[5], c[12:10], c[6], 2'b00};
            r.instr = {imm, rs1p, 3'b010, rdp, 7'b0000011};
          end
          3'b011: begin  // C.LD
            imm     = {4'b0, c[6:5], c[12:10], 3'b000};
            r.instr = {imm, rs1p, 3'b011, rdp, 7'b0000011};
          end
          3'b110: begin  // C.SW
            imm     = {5'b0, c[5], c[12:10], c[6], 2'b00};
            r.instr = {imm[11:5], rdp, rs1p, 3'b010, imm[4:0], 7'b0100011};
          end
          3'b111: begin  // C.SD
            imm     = {4'b0, c[6:5], c[12:10], 3'b000};
            r.instr = {imm[11:5], rdp, rs1p, 3'b011, imm[4:0], 7'b0100011};
          end
          default: r.illegal = 1'b1;  // C.FLD, C.FSD, reserved
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: r.instr = {imm6, rd, 3'b000, rd, 7'b0010011};  // C.ADDI / C.NOP
          3'b001: begin  // C.ADDIW
            r.instr   = {imm6, rd, 3'b000, rd, 7'b0011011};
            r.illegal = (rd == 5'd0);
          end
          3'b010: r.instr = {imm6, 5'd0, 3'b000, rd, 7'b0010011};  // C.LI
          3'b011: begin
            if (rd == 5'd2) begin  // C.ADDI16SP
              imm     = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
              r.instr = {imm, 5'd2, 3'b000, 5'd2, 7'b0010011};
            end else begin  // C.LUI
              r.instr = {{15{c[12]}}, c[6:2], rd, 7'b0110111};
            end
            r.illegal = ({c[12], c[6:2]} == 6'h0);
          end
          3'b100: begin
            case (c[11:10])
              2'b00: r.instr = {6'b000000, c[12], c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
              2'b01: r.instr = {6'b010000, c[12], c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
              2'b10: r.instr = {imm6, rs1p, 3'b111, rs1p, 7'b0010011};
              default: begin
                case ({c[12], c[6:5]})
                  3'b000: r.instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0110011};
                  3'b001: r.instr = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'b0110011};
                  3'b010: r.instr = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'b0110011};
                  3'b011: r.instr = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'b0110011};
                  3'b100: r.instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0111011};
                  3'b101: r.instr = {7'b0000000, rdp, rs1p, 3'b000, rs1p, 7'b0111011};
                  default: r.illegal = 1'b1;
                endcase
              end
            endcase
          end
          3'b101: r.instr = {j_off[11], j_off[10:1], j_off[11], {8{j_off[11]}}, 5'd0, 7'b1101111};
          default: r.instr = {b_off[12], b_off[10:5], 5'd0, rs1p, 2'b00, c[13],
                              b_off[4:1], b_off[11], 7'b1100011};  // C.BEQZ / C.BNEZ
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: r.instr = {6'b000000, c[12], c[6:2], rd, 3'b001, rd, 7'b0010011};  // C.SLLI
          3'b010: begin  // C.LWSP
            imm       = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
            r.instr   = {imm, 5'd2, 3'b010, rd, 7'b0000011};
            r.illegal = (rd == 5'd0);
          end
          3'b011: begin  // C.LDSP
            imm       = {3'b0, c[4:2], c[12], c[6:5], 3'b000};
            r.instr   = {imm, 5'd2, 3'b011, rd, 7'b0000011};
            r.illegal = (rd == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin  // C.JR
                r.instr   = {12'h0, rd, 3'b000, 5'd0, 7'b1100111};
                r.illegal = (rd == 5'd0);
              end else begin  // C.MV
                r.instr = {7'b0, rs2, 5'd0, 3'b000, rd, 7'b0110011};
              end
            end else if (rs2 == 5'd0) begin
              if (rd == 5'd0) r.instr = 32'h0010_0073;                     // C.EBREAK
              else            r.instr = {12'h0, rd, 3'b000, 5'd1, 7'b1100111};  // C.JALR
            end else begin  // C.ADD
              r.instr = {7'b0, rs2, rd, 3'b000, rd, 7'b0110011};
            end
          end
          3'b110: begin  // C.SWSP
            imm     = {4'b0, c[8:7], c[12:9], 2'b00};
            r.instr = {imm[11:5], rs2, 5'd2, 3'b010, imm[4:0], 7'b0100011};
          end
          3'b111: begin  // C.SDSP
            imm     = {3'b0, c[9:7], c[12:10], 3'b000};
            r.instr = {imm[11:5], rs2, 5'd2, 3'b011, imm[4:0], 7'b0100011};
          end
          default: r.illegal = 1'b1;  // C.FLDSP, C.FSDSP
        endcase
      end
      default: r.illegal = 1'b1;
    endcase
    if (r.illegal) r.instr = {16'h0, c};
    return r;
  endfunction

  expand_t exp_c;

  // Decode the head of the buffer: raw 32-bit word or expanded compressed form.
  always_comb begin
    exp_c        = expand(hw[0]);
    is32         = (hw[0][1:0] == 2'b11);
    redirect_eff = redirect_pc_i;
    if (is32) begin
      out_instr = {hw[1], hw[0]};
      out_comp  = 1'b0;
      out_ill   = 1'b0;
    end else begin
      out_instr = exp_c.instr;
      out_comp  = 1'b1;
      out_ill   = exp_c.illegal;
    end
  end
`else
  // Without the expander every output is a whole word; short encodings are illegal.
  always_comb begin
    is32         = 1'b1;
    out_instr    = {hw[1], hw[0]};
    out_comp     = 1'b0;
    out_ill      = (hw[0][1:0] != 2'b11);
    redirect_eff = redirect_pc_i & ~64'h2;
  end
`endif

  // Handshake: output when enough halfwords are present, accept a word when two slots free up.
  always_comb begin
    need          = is32 ? 2'd2 : 2'd1;
    out_valid     = (count >= need);
    xfer          = out_valid && id_ready_i && !flush_i;
    consume       = xfer ? need : 2'd0;
    remain        = count - consume;
    fetch_ready_o = !flush_i && (remain <= 2'd1);
    accept        = fetch_valid_i && fetch_ready_o;
  end

  // Next buffer state: shift out consumed halfwords, then append the new word.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    hw_nxt      = hw;
    count_nxt   = remain;
    base_pc_nxt = base_pc + {61'd0, consume, 1'b0};
    skip_lo_nxt = skip_lo;
    if (consume == 2'd1) begin
      hw_nxt[0] = hw[1];
      hw_nxt[1] = hw[2];
    end else if (consume == 2'd2) begin
      hw_nxt[0] = hw[2];
    end
    if (accept) begin
      if (skip_lo) begin
        // First word after a halfword redirect: its low half precedes the target.
        hw_nxt[remain] = fetch_data_i[31:16];
        count_nxt      = remain + 2'd1;
        base_pc_nxt    = fetch_pc_i + 64'd2;
        skip_lo_nxt    = 1'b0;
      end else begin
        if (remain == 2'd0) begin
          hw_nxt[0] = fetch_data_i[15:0];
          hw_nxt[1] = fetch_data_i[31:16];
        end else begin
          hw_nxt[1] = fetch_data_i[15:0];
          hw_nxt[2] = fetch_data_i[31:16];
        end
        count_nxt = remain + 2'd2;
      end
    end
    if (flush_i) begin
      count_nxt   = 2'd0;
      base_pc_nxt = redirect_eff;
      skip_lo_nxt = redirect_eff[1];
    end
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the three-entry buffer is reset along with the control state so
      // the decoded head is never X, even though count=0 masks it.
      for (int i = 0; i < 3; i++) hw[i] <= 16'h0;
      count   <= 2'd0;
      base_pc <= RESET_PC;
      skip_lo <= 1'b0;
    end else begin
      hw      <= hw_nxt;
      count   <= count_nxt;
      base_pc <= base_pc_nxt;
      skip_lo <= skip_lo_nxt;
    end
  end

  // Outputs are driven from registers only and read as zero while nothing is valid.
  always_comb begin
    if_id_o      = '0;
    compressed_o = 1'b0;
    illegal_o    = 1'b0;
    if (out_valid) begin
      if_id_o.valid       = 1'b1;
      if_id_o.PC          = base_pc;
      if_id_o.instruction = out_instr;
      compressed_o        = out_comp;
      illegal_o           = out_ill;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner: stimulus pushes hand-computed expected
// outputs, a monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_fetch_aligner;
  import WivDefines::*;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [63:0] fetch_pc = '0;
  logic [31:0] fetch_data = '0;
  IF_ID_t      if_id;
  logic        id_ready = 1'b1;
  logic        compressed;
  logic        illegal;
  logic        flush = 1'b0;
  logic [63:0] redirect_pc = '0;

  fetch_aligner #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid_i (fetch_valid),
    .fetch_ready_o (fetch_ready),
    .fetch_pc_i    (fetch_pc),
    .fetch_data_i  (fetch_data),
    .if_id_o       (if_id),
    .id_ready_i    (id_ready),
    .compressed_o  (compressed),
    .illegal_o     (illegal),
    .flush_i       (flush),
    .redirect_pc_i (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        comp;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_out(input logic [63:0] pc, input logic [31:0] instr,
                            input logic comp, input logic ill);
    exp_t e;
    e.pc = pc; e.instr = instr; e.comp = comp; e.ill = ill;
    exp_q.push_back(e);
  endtask

  // Monitor: every output transfer must match the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !flush && if_id.valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %0h instr %0h expected none",
                   if_id.PC, if_id.instruction);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", if_id.PC, e.pc);
          check("out_instr", if_id.instruction, e.instr);
          check("out_compressed", compressed, e.comp);
          check("out_illegal", illegal, e.ill);
        end
      end
    end
  end

  // Present one word and hold it until the aligner takes it (bounded).
  task automatic send_word(input logic [63:0] pc, input logic [31:0] data);
    int   n = 0;
    logic acc = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_data  = data;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = fetch_ready;
      @(posedge clk); #1;
      n++;
    end
    check("fetch_accept", acc, 1'b1);
    fetch_valid = 1'b0;
  endtask

  // One-cycle redirect, optionally with a word offered in the same cycle.
  task automatic redirect(input logic [63:0] pc, input logic with_word);
    flush       = 1'b1;
    redirect_pc = pc;
    fetch_valid = with_word;
    fetch_pc    = {pc[63:2], 2'b00};
    fetch_data  = 32'h0000_0513;
    @(negedge clk);
    check("flush_ready", fetch_ready, 1'b0);
    @(posedge clk); #1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty within a cycle budget.
  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // Build up a backpressured buffer with no expectations queued.
  task automatic fill_buffer(input logic [63:0] base);
    id_ready = 1'b0;
`ifdef WIV_RVC_EN
    redirect(base + 64'd2, 1'b0);
    send_word(base, 32'h4505_4501);
    send_word(base + 64'd4, 32'h0513_4501);
`else
    redirect(base, 1'b0);
    send_word(base, 32'h0000_0513);
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #2 rst_n = 1'b0;
    #10;
    check("reset_if_id", if_id, '0);
    check("reset_compressed", compressed, 1'b0);
    check("reset_illegal", illegal, 1'b0);
    check("reset_fetch_ready", fetch_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef WIV_RVC_EN
    // Two C.LI in one word.
    expect_out(64'h8000_0000, 32'h0000_0513, 1'b1, 1'b0);
    expect_out(64'h8000_0002, 32'h0010_0513, 1'b1, 1'b0);
    send_word(64'h8000_0000, 32'h4505_4501);
    wait_drain(4, "cli_pair_drain");

    // 32-bit instruction straddling two words.
    redirect(64'h8000_0000, 1'b0);
    expect_out(64'h8000_0000, 32'h0000_0513, 1'b1, 1'b0);
    expect_out(64'h8000_0002, 32'h0000_0513, 1'b0, 1'b0);
    expect_out(64'h8000_0006, 32'h0010_0513, 1'b1, 1'b0);
    send_word(64'h8000_0000, 32'h0513_4501);
    send_word(64'h8000_0004, 32'h4505_0000);
    wait_drain(4, "straddle_drain");

    // Halfword redirect; the word offered during the flush is dropped.
    redirect(64'h8000_0102, 1'b1);
    expect_out(64'h8000_0102, 32'h0010_0513, 1'b1, 1'b0);
    send_word(64'h8000_0100, 32'h4505_4501);
    wait_drain(4, "hw_redirect_drain");

    // Illegal all-zero halfword followed by a legal one.
    redirect(64'h8000_0200, 1'b0);
    expect_out(64'h8000_0200, 32'h0000_0000, 1'b1, 1'b1);
    expect_out(64'h8000_0202, 32'h0000_0513, 1'b1, 1'b0);
    send_word(64'h8000_0200, 32'h4501_0000);
    wait_drain(4, "illegal_drain");

    // C.MV, C.ADD, C.JR (ret), then a zero halfword.
    redirect(64'h8000_0300, 1'b0);
    expect_out(64'h8000_0300, 32'h00b0_0533, 1'b1, 1'b0);
    expect_out(64'h8000_0302, 32'h00b5_0533, 1'b1, 1'b0);
    expect_out(64'h8000_0304, 32'h0000_8067, 1'b1, 1'b0);
    expect_out(64'h8000_0306, 32'h0000_0000, 1'b1, 1'b1);
    send_word(64'h8000_0300, 32'h952E_852E);
    send_word(64'h8000_0304, 32'h0000_8082);
    wait_drain(6, "c2_mix_drain");
`else
    // Back-to-back 32-bit words.
    expect_out(64'h8000_0000, 32'h0000_0513, 1'b0, 1'b0);
    expect_out(64'h8000_0004, 32'h0010_0593, 1'b0, 1'b0);
    expect_out(64'h8000_0008, 32'h00b5_0633, 1'b0, 1'b0);
    send_word(64'h8000_0000, 32'h0000_0513);
    send_word(64'h8000_0004, 32'h0010_0593);
    send_word(64'h8000_0008, 32'h00b5_0633);
    wait_drain(3, "stream_drain");

    // A non-32-bit encoding is illegal and passes the raw word through.
    redirect(64'h8000_0200, 1'b0);
    expect_out(64'h8000_0200, 32'h4501_0000, 1'b0, 1'b1);
    expect_out(64'h8000_0204, 32'h0000_0513, 1'b0, 1'b0);
    send_word(64'h8000_0200, 32'h4501_0000);
    send_word(64'h8000_0204, 32'h0000_0513);
    wait_drain(4, "illegal_drain");

    // Halfword bit of the redirect is ignored; the word offered during the flush is dropped.
    redirect(64'h8000_0102, 1'b1);
    expect_out(64'h8000_0100, 32'h00a0_0513, 1'b0, 1'b0);
    send_word(64'h8000_0100, 32'h00a0_0513);
    wait_drain(4, "hw_redirect_drain");
`endif

    // Flush discards buffered instructions.
    redirect(64'h8000_0400, 1'b0);
    id_ready = 1'b0;
    send_word(64'h8000_0400, 32'h0000_0513);
    @(negedge clk);
    check("held_valid", if_id.valid, 1'b1);
    @(posedge clk); #1;
    redirect(64'h8000_0500, 1'b0);
    id_ready = 1'b1;
    check("flushed_valid", if_id.valid, 1'b0);
    expect_out(64'h8000_0500, 32'h0010_0593, 1'b0, 1'b0);
    send_word(64'h8000_0500, 32'h0010_0593);
    wait_drain(4, "post_flush_drain");

    // Backpressure with a full buffer and a word waiting.
    fill_buffer(64'h8000_0600);
`ifdef WIV_RVC_EN
    expect_out(64'h8000_0602, 32'h0010_0513, 1'b1, 1'b0);
    expect_out(64'h8000_0604, 32'h0000_0513, 1'b1, 1'b0);
    expect_out(64'h8000_0606, 32'h0000_0513, 1'b0, 1'b0);
    expect_out(64'h8000_060a, 32'h0000_0013, 1'b1, 1'b0);
    fetch_valid = 1'b1; fetch_pc = 64'h8000_0608; fetch_data = 32'h0001_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_fetch_ready", fetch_ready, 1'b0);
      check("bp_valid", if_id.valid, 1'b1);
      check("bp_pc", if_id.PC, 64'h8000_0602);
      check("bp_instr", if_id.instruction, 32'h0010_0513);
      check("bp_compressed", compressed, 1'b1);
      @(posedge clk); #1;
    end
    id_ready = 1'b1;
    send_word(64'h8000_0608, 32'h0001_0000);
`else
    expect_out(64'h8000_0600, 32'h0000_0513, 1'b0, 1'b0);
    expect_out(64'h8000_0604, 32'h0010_0593, 1'b0, 1'b0);
    fetch_valid = 1'b1; fetch_pc = 64'h8000_0604; fetch_data = 32'h0010_0593;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_fetch_ready", fetch_ready, 1'b0);
      check("bp_valid", if_id.valid, 1'b1);
      check("bp_pc", if_id.PC, 64'h8000_0600);
      check("bp_instr", if_id.instruction, 32'h0000_0513);
      check("bp_compressed", compressed, 1'b0);
      @(posedge clk); #1;
    end
    id_ready = 1'b1;
    send_word(64'h8000_0604, 32'h0010_0593);
`endif
    wait_drain(8, "backpressure_drain");

    // Reset mid-stream with a full buffer.
    fill_buffer(64'h8000_0700);
    @(negedge clk);
    check("pre_reset_valid", if_id.valid, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset_async_valid", if_id.valid, 1'b0);
    check("reset_async_ready", fetch_ready, 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n    = 1'b1;
    id_ready = 1'b1;
`ifdef WIV_RVC_EN
    expect_out(RESET_PC, 32'h0000_0513, 1'b1, 1'b0);
    expect_out(RESET_PC + 64'd2, 32'h0010_0513, 1'b1, 1'b0);
    send_word(RESET_PC, 32'h4505_4501);
`else
    expect_out(RESET_PC, 32'h0000_0513, 1'b0, 1'b0);
    send_word(RESET_PC, 32'h0000_0513);
`endif
    wait_drain(4, "post_reset_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
